// File: rtl/spiflash_target.sv
// SPI NOR flash target: serves single-bit (03/0B) and quad (EB) reads from a
// byte-wide backing memory through a one-byte prefetch buffer. All SPI pads are
// oversampled by the system clock, which must run at least 6x the SPI clock.
module spiflash_target #(
  parameter int ADDR_BYTES = 3,
  parameter int DUMMY_FAST = 8,
  parameter int DUMMY_QUAD = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    spi_csb,
  input  logic                    spi_clk,
  input  logic [3:0]              spi_io_di,
  output logic [3:0]              spi_io_do,
  output logic [3:0]              spi_io_oe,
  output logic                    mem_valid,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  input  logic                    mem_ready,
  input  logic [7:0]              mem_rdata,
  output logic                    powered_up,
  output logic                    xip_active,
  output logic                    underrun
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam logic [5:0] ADDR_LAST_S = 6'(AW - 1);
  localparam logic [5:0] ADDR_LAST_Q = 6'(2 * ADDR_BYTES - 1);
  localparam logic [5:0] DUM_LAST_F  = 6'(DUMMY_FAST - 1);
  localparam logic [5:0] DUM_LAST_Q  = 6'(DUMMY_QUAD - 1);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE} state_t;

  logic          csb_p0, csb_p1;
  logic          sclk_p0, sclk_p1, sclk_p2;
  logic [3:0]    io_p0, io_p1;
  logic          spi_rise, spi_fall;

  state_t        state;
  logic [5:0]    cnt;
  logic          quad, fast;
  logic [2:0]    out_cnt;
  logic          pf_valid, req_en;

  logic [6:0]    cmd_sr;
  logic [AW-2:0] addr_sr;
  logic [3:0]    mode_hi;
  logic [7:0]    out_sr, pf_data;

  logic [7:0]    cmd_next, mode_next, load_byte, cur_byte, out_next;
  logic [AW-1:0] addr_next;
  logic [3:0]    do_next;
  logic          byte_start;

  // Two-flop synchronisers for the asynchronous SPI pads, plus SPI clock history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csb_p0  <= 1'b1;
      csb_p1  <= 1'b1;
      sclk_p0 <= 1'b0;
      sclk_p1 <= 1'b0;
      sclk_p2 <= 1'b0;
      io_p0   <= '0;
      io_p1   <= '0;
    end else begin
      // stage p0 -> p1: metastability settling
      csb_p0  <= spi_csb;
      csb_p1  <= csb_p0;
      sclk_p0 <= spi_clk;
      sclk_p1 <= sclk_p0;
      io_p0   <= spi_io_di;
      io_p1   <= io_p0;
      // stage p1 -> p2: previous SPI clock level for edge detection
      sclk_p2 <= sclk_p1;
    end
  end

  assign spi_rise = sclk_p1 & ~sclk_p2;
  assign spi_fall = ~sclk_p1 & sclk_p2;

  assign cmd_next   = {cmd_sr, io_p1[0]};
  assign mode_next  = {mode_hi, io_p1};
  assign addr_next  = quad ? {addr_sr[AW-5:0], io_p1} : {addr_sr, io_p1[0]};

  // Byte boundary: the shift register reloads from the prefetch buffer, or 00
  // when memory has not delivered in time.
  assign byte_start = (out_cnt == 3'd0);
  assign load_byte  = pf_valid ? pf_data : 8'h00;
  assign cur_byte   = byte_start ? load_byte : out_sr;
  assign out_next   = quad ? {cur_byte[3:0], 4'h0} : {cur_byte[6:0], 1'b0};
  assign do_next    = quad ? cur_byte[7:4] : {2'b00, cur_byte[7], 1'b0};

  // Datapath shift registers and prefetch byte; contents are qualified by control
  always_ff @(posedge clk) begin
    if (mem_valid && mem_ready) pf_data <= mem_rdata;
    if (spi_rise) begin
      cmd_sr  <= cmd_next[6:0];
      addr_sr <= addr_next[AW-2:0];
      mode_hi <= io_p1;
    end
    if (spi_fall && state == DATA) out_sr <= out_next;
  end

  // Transaction FSM, memory request handshake and pad output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      quad       <= 1'b0;
      fast       <= 1'b0;
      out_cnt    <= '0;
      spi_io_do  <= '0;
      spi_io_oe  <= '0;
      mem_valid  <= 1'b0;
      mem_addr   <= '0;
      pf_valid   <= 1'b0;
      req_en     <= 1'b0;
      powered_up <= 1'b0;
      xip_active <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      if (mem_valid && mem_ready) begin
        pf_valid  <= 1'b1;
        mem_valid <= 1'b0;
        mem_addr  <= mem_addr + AW'(1);
      end else if (req_en && !pf_valid && !mem_valid) begin
        mem_valid <= 1'b1;
      end

      if (csb_p1) begin
        state     <= IDLE;
        cnt       <= '0;
        out_cnt   <= '0;
        spi_io_do <= '0;
        spi_io_oe <= '0;
        mem_valid <= 1'b0;
        pf_valid  <= 1'b0;
        req_en    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            cnt <= '0;
            if (xip_active) begin
              state <= ADDR;
              quad  <= 1'b1;
              fast  <= 1'b0;
            end else begin
              state <= CMD;
            end
          end
          CMD: if (spi_rise) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd7) begin
              cnt   <= '0;
              state <= IGNORE;
              unique case (cmd_next)
                8'hAB: powered_up <= 1'b1;
                8'hB9: powered_up <= 1'b0;
                8'hFF: xip_active <= 1'b0;
                8'h03, 8'h0B, 8'hEB: if (powered_up) begin
                  state <= ADDR;
                  quad  <= (cmd_next == 8'hEB);
                  fast  <= (cmd_next == 8'h0B);
                end
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (spi_rise) begin
            cnt <= cnt + 6'd1;
            if (cnt == (quad ? ADDR_LAST_Q : ADDR_LAST_S)) begin
              cnt       <= '0;
              out_cnt   <= '0;
              mem_addr  <= addr_next;
              mem_valid <= 1'b1;
              pf_valid  <= 1'b0;
              req_en    <= 1'b1;
              state     <= quad ? MODE : (fast ? DUMMY : DATA);
            end
          end
          MODE: if (spi_rise) begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'd1) begin
              cnt        <= '0;
              xip_active <= (mode_next == 8'hA5);
              state      <= DUMMY;
            end
          end
          DUMMY: if (spi_rise) begin
            cnt <= cnt + 6'd1;
            if (cnt == (quad ? DUM_LAST_Q : DUM_LAST_F)) begin
              cnt     <= '0;
              out_cnt <= '0;
              state   <= DATA;
            end
          end
          DATA: if (spi_fall) begin
            spi_io_do <= do_next;
            spi_io_oe <= quad ? 4'b1111 : 4'b0010;
            if (byte_start) begin
              out_cnt <= quad ? 3'd1 : 3'd7;
              if (pf_valid) pf_valid <= 1'b0;
              else          underrun <= 1'b1;
            end else begin
              out_cnt <= out_cnt - 3'd1;
            end
          end
          IGNORE: cnt <= '0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/spiflash_target.md
SPIFLASH_TARGET -- requirements
Module: spiflash_target

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 3; address bytes per command, legal values 3 and 4; address width AW = 8*ADDR_BYTES.
REQ-002 SHALL have parameter DUMMY_FAST, default 8; dummy SPI clocks for command 0B.
REQ-003 SHALL have parameter DUMMY_QUAD, default 4; dummy SPI clocks after the mode byte of command EB.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 spi_csb  input  1  SPI chip select, active low, asynchronous to clk.
REQ-007 spi_clk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 spi_io_di  input  4  io3..io0 pad inputs.
REQ-009 spi_io_do  output  4  io3..io0 pad output values.
REQ-010 spi_io_oe  output  4  io3..io0 pad output enables.
REQ-011 mem_valid  output  1  backing-memory byte read request.
REQ-012 mem_addr  output  AW  request byte address.
REQ-013 mem_ready  input  1  request accepted; mem_rdata valid this cycle.
REQ-014 mem_rdata  input  8  read byte.
REQ-015 powered_up  output  1  device awake.
REQ-016 xip_active  output  1  continuous-read (XIP) mode armed.
REQ-017 underrun  output  1  sticky: a data byte was needed before memory returned it.

Function
REQ-018 spi_csb, spi_clk and spi_io_di SHALL pass through 2-FF synchronisers; rise/fall events derive from synchronised spi_clk versus its previous value.
REQ-019 Correct operation SHALL require clk frequency >= 6x spi_clk frequency.
REQ-020 Inputs SHALL be sampled on rise events; outputs SHALL update on fall events; pad-to-event latency 3 clk cycles.
REQ-021 States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
REQ-022 Synchronised csb high SHALL force IDLE, clear bit counters, drive spi_io_oe=0000, deassert mem_valid, discard the prefetch buffer and any outstanding request.
REQ-023 csb falling: xip_active=1 -> ADDR with implied command EB; else -> CMD.
REQ-024 CMD: 8 bits on io0, MSB first; decode on 8th rise.
REQ-025 AB -> powered_up=1, IGNORE; B9 -> powered_up=0, IGNORE; FF -> xip_active=0, IGNORE.
REQ-026 03, 0B, EB with powered_up=1 -> ADDR; any other byte, or powered_up=0 -> IGNORE.
REQ-027 ADDR: 03/0B take AW rises on io0; EB takes 2*ADDR_BYTES rises, nibble {io3,io2,io1,io0}, MSB first.
REQ-028 After address: 03 -> DATA; 0B -> DUMMY (DUMMY_FAST rises); EB -> MODE.
REQ-029 MODE: 2 quad rises; xip_active := (mode byte == A5); then DUMMY (DUMMY_QUAD rises).
REQ-030 spi_io_oe SHALL be 0000 in CMD, ADDR, MODE, DUMMY, IGNORE.
REQ-031 On address completion SHALL assert mem_valid with mem_addr = received address, held stable until mem_ready.
REQ-032 On mem_ready SHALL capture mem_rdata into a one-byte prefetch buffer, increment address modulo 2^AW, and request the next byte once the buffer is emptied.
REQ-033 DATA: at each byte boundary the shift register SHALL load from the prefetch buffer; if empty, load 00 and set underrun.
REQ-034 DATA 03/0B: on each fall drive spi_io_do[1] = next bit MSB first, spi_io_oe=0010.
REQ-035 DATA EB: on each fall drive high nibble then low nibble on io3..io0, spi_io_oe=1111.
REQ-036 The first data output SHALL occur on the fall following the last address (03) or last dummy (0B/EB) rise.
REQ-037 DATA SHALL continue indefinitely until csb high.

Reset
REQ-038 reset SHALL asynchronously set state IDLE, spi_io_oe=0000, spi_io_do=0000, mem_valid=0, mem_addr=0, powered_up=0, xip_active=0, underrun=0, prefetch empty; applies mid-transaction.

Verification
REQ-039 After reset, 03 000100 without AB -> spi_io_oe stays 0000, mem_valid never asserted.
REQ-040 AB, then 03 000100, memory returns 5A,3C -> mem_addr 000100,000101; io1 shows 01011010 00111100.
REQ-041 EB 000010, mode A5, 4 dummy, memory 12,34 -> io nibbles 1,2,3,4; xip_active=1; next transaction with address 000020 only returns memory[000020]; FF clears xip_active.
REQ-042 mem_ready held low during 03 -> output byte 00, underrun=1 until reset.
REQ-043 03 FFFFFF read 2 bytes -> mem_addr FFFFFF then 000000.
REQ-044 csb high mid-address, and reset mid-DATA -> spi_io_oe=0000, mem_valid=0 within 3 clk (csb) or immediately (reset); next AB/03 decodes correctly.
